// File: rtl/pcs_block_sync_pkg.sv
// Shared definitions for the PCS block-sync lane controller: one-hot state
// encodings and default parameter values.
package pcs_block_sync_pkg;

  localparam int unsigned N_LANES_DEFAULT    = 20;
  localparam int unsigned NB_TIMEOUT_DEFAULT = 16;
  localparam int unsigned NB_RETRY_DEFAULT   = 4;

  localparam logic [3:0] ST_IDLE       = 4'b0001;
  localparam logic [3:0] ST_WAIT_LOCK  = 4'b0010;
  localparam logic [3:0] ST_ALL_LOCKED = 4'b0100;
  localparam logic [3:0] ST_FAIL       = 4'b1000;

  typedef enum logic [3:0] {
    StIdle      = ST_IDLE,
    StWaitLock  = ST_WAIT_LOCK,
    StAllLocked = ST_ALL_LOCKED,
    StFail      = ST_FAIL
  } state_e;

endpackage

// File: rtl/block_sync_timeout_timer.sv
// Lock-attempt timer: counts qualified blocks and flags when the count equals
// the programmed threshold. Wraps at NB_TIMEOUT bits.
module block_sync_timeout_timer
  import pcs_block_sync_pkg::*;
#(
  parameter int unsigned NB_TIMEOUT = NB_TIMEOUT_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic                  i_count_en,
  input  logic [NB_TIMEOUT-1:0] i_threshold,
  output logic                  o_done
);

  logic [NB_TIMEOUT-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (i_clear) begin
        r_count <= '0;
      end else if (i_count_en) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Compared against the live threshold so a change applies at the next compare.
  assign o_done = (r_count == i_threshold);

endmodule

// File: rtl/block_sync_lane_ctrl.sv
// Multi-lane block-sync supervisor: restarts unlocked lanes on timeout, retries,
// and declares failure. Optional loss counter under BLOCK_SYNC_LOSS_CNT_EN.
module block_sync_lane_ctrl
  import pcs_block_sync_pkg::*;
#(
  parameter int unsigned N_LANES    = N_LANES_DEFAULT,
  parameter int unsigned NB_TIMEOUT = NB_TIMEOUT_DEFAULT,
  parameter int unsigned NB_RETRY   = NB_RETRY_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [N_LANES-1:0]    i_signal_ok,
  input  logic [N_LANES-1:0]    i_block_lock,
  input  logic [NB_TIMEOUT-1:0] i_rf_lock_timeout,
  input  logic [NB_RETRY-1:0]   i_rf_max_retry,
  output logic [N_LANES-1:0]    o_lane_restart,
  output logic                  o_all_locked,
  output logic                  o_lock_fail,
`ifdef BLOCK_SYNC_LOSS_CNT_EN
  output logic [15:0]           o_lock_loss_count,
`endif
  output logic [NB_RETRY-1:0]   o_retry_count
);

  state_e               r_state, w_state_d;
  logic [NB_RETRY-1:0]  r_retry, w_retry_d;
  logic [N_LANES-1:0]   r_restart, w_restart_d;
  logic                 w_all_ok, w_all_lock;
  logic                 w_timer_done, w_timer_clear, w_timeout;

  assign w_all_ok   = &i_signal_ok;
  assign w_all_lock = &i_block_lock;

  always_comb begin
    w_state_d   = r_state;
    w_retry_d   = r_retry;
    w_restart_d = '0;
    w_timeout   = 1'b0;
    if (!w_all_ok) begin
      w_state_d = StIdle;
      w_retry_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_retry_d = '0;
          w_state_d = StWaitLock;
        end
        StWaitLock: begin
          if (w_all_lock) begin
            w_state_d = StAllLocked;
          end else if (w_timer_done) begin
            w_timeout = 1'b1;
            // >= keeps the count from wrapping if the limit is lowered mid-run.
            if (r_retry >= i_rf_max_retry) begin
              w_state_d = StFail;
            end else begin
              w_restart_d = ~i_block_lock;
              w_retry_d   = r_retry + 1'b1;
            end
          end
        end
        StAllLocked: begin
          if (!w_all_lock) begin
            w_state_d = StWaitLock;
            w_retry_d = '0;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: begin
          w_state_d = StIdle;
          w_retry_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_retry   <= '0;
      r_restart <= '0;
    end else if (i_enable) begin
      r_state   <= w_state_d;
      r_retry   <= w_retry_d;
      r_restart <= w_restart_d;
    end
  end

  // Timer only runs while staying in WAIT_LOCK; every other path starts it from zero.
  assign w_timer_clear = (r_state != StWaitLock) || (w_state_d != StWaitLock) || w_timeout;

  block_sync_timeout_timer #(
    .NB_TIMEOUT (NB_TIMEOUT)
  ) u_timer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_clear     (w_timer_clear),
    .i_count_en  (i_valid),
    .i_threshold (i_rf_lock_timeout),
    .o_done      (w_timer_done)
  );

`ifdef BLOCK_SYNC_LOSS_CNT_EN
  logic [15:0] r_loss_count;
  logic        w_lock_lost;

  assign w_lock_lost = (r_state == StAllLocked) && w_all_ok && !w_all_lock;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_loss_count <= '0;
    end else if (i_enable && w_lock_lost && (r_loss_count != 16'hFFFF)) begin
      r_loss_count <= r_loss_count + 16'd1;
    end
  end

  assign o_lock_loss_count = r_loss_count;
`endif

  assign o_lane_restart = r_restart;
  assign o_all_locked   = (r_state == StAllLocked);
  assign o_lock_fail    = (r_state == StFail);
  assign o_retry_count  = r_retry;

endmodule

// File: tb/tb_block_sync_lane_ctrl.sv
// Self-checking bench for block_sync_lane_ctrl: directed scenarios plus a
// randomized run against a behavioural model.
module tb_block_sync_lane_ctrl;

  localparam int NL  = 20;
  localparam int NBT = 16;
  localparam int NBR = 4;

  logic            i_clock = 1'b0;
  logic            i_reset, i_enable, i_valid;
  logic [NL-1:0]   i_signal_ok, i_block_lock;
  logic [NBT-1:0]  i_rf_lock_timeout;
  logic [NBR-1:0]  i_rf_max_retry;
  logic [NL-1:0]   o_lane_restart;
  logic            o_all_locked, o_lock_fail;
  logic [NBR-1:0]  o_retry_count;
`ifdef BLOCK_SYNC_LOSS_CNT_EN
  logic [15:0]     o_lock_loss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 hunting for lock, 2 all locked, 3 failed.
  int            m_phase, m_timer, m_retry, m_loss;
  logic [NL-1:0] m_restart;

  always #5 i_clock = ~i_clock;

  block_sync_lane_ctrl dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_enable          (i_enable),
    .i_valid           (i_valid),
    .i_signal_ok       (i_signal_ok),
    .i_block_lock      (i_block_lock),
    .i_rf_lock_timeout (i_rf_lock_timeout),
    .i_rf_max_retry    (i_rf_max_retry),
    .o_lane_restart    (o_lane_restart),
    .o_all_locked      (o_all_locked),
    .o_lock_fail       (o_lock_fail),
`ifdef BLOCK_SYNC_LOSS_CNT_EN
    .o_lock_loss_count (o_lock_loss_count),
`endif
    .o_retry_count     (o_retry_count)
  );

  task automatic model_step();
    logic [NL-1:0] pulse;
    pulse = '0;
    if (i_reset) begin
      m_phase = 0; m_timer = 0; m_retry = 0; m_loss = 0; m_restart = '0;
    end else if (i_enable) begin
      if (i_signal_ok != '1) begin
        m_phase = 0; m_timer = 0; m_retry = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_timer = 0; m_retry = 0;
      end else if (m_phase == 1) begin
        if (i_block_lock == '1) begin
          m_phase = 2; m_timer = 0;
        end else if (m_timer == int'(i_rf_lock_timeout)) begin
          m_timer = 0;
          if (m_retry >= int'(i_rf_max_retry)) m_phase = 3;
          else begin
            pulse   = ~i_block_lock;
            m_retry = m_retry + 1;
          end
        end else if (i_valid) begin
          m_timer = (m_timer + 1) % (1 << NBT);
        end
      end else if (m_phase == 2) begin
        if (i_block_lock != '1) begin
          m_phase = 1; m_timer = 0; m_retry = 0;
          if (m_loss < 65535) m_loss = m_loss + 1;
        end
      end
      m_restart = pulse;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cycle();
    i_reset = 1'b0;
    i_enable = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b1;
    i_signal_ok = '1; i_block_lock = '1;
    i_rf_lock_timeout = 16'd5; i_rf_max_retry = 4'd1;
    cycle(); cycle();
    i_reset = 1'b0;
    n_tests++; if (o_lane_restart !== '0) begin n_fail++;
      $display("FAIL reset_restart got=%h exp=0", o_lane_restart); end
    n_tests++; if (o_all_locked !== 1'b0) begin n_fail++;
      $display("FAIL reset_all_locked got=%b exp=0", o_all_locked); end
    n_tests++; if (o_lock_fail !== 1'b0) begin n_fail++;
      $display("FAIL reset_lock_fail got=%b exp=0", o_lock_fail); end
    n_tests++; if (o_retry_count !== '0) begin n_fail++;
      $display("FAIL reset_retry got=%0d exp=0", o_retry_count); end
`ifdef BLOCK_SYNC_LOSS_CNT_EN
    n_tests++; if (o_lock_loss_count !== '0) begin n_fail++;
      $display("FAIL reset_loss got=%0d exp=0", o_lock_loss_count); end
`endif
  endtask

  task automatic test_lockup();
    logic [NL-1:0] seen;
    do_reset();
    i_rf_lock_timeout = 16'd50; i_rf_max_retry = 4'd3;
    i_signal_ok = '1; i_block_lock = '0; i_valid = 1'b1;
    cycle();
    seen = '0;
    repeat (10) begin cycle(); seen |= o_lane_restart; end
    i_block_lock = '1;
    cycle();
    seen |= o_lane_restart;
    n_tests++; if (o_all_locked !== 1'b1) begin n_fail++;
      $display("FAIL lockup_all_locked got=%b exp=1", o_all_locked); end
    n_tests++; if (seen !== '0) begin n_fail++;
      $display("FAIL lockup_no_restart got=%h exp=0", seen); end
    n_tests++; if (o_retry_count !== '0) begin n_fail++;
      $display("FAIL lockup_retry got=%0d exp=0", o_retry_count); end
  endtask

  task automatic test_partial_timeout();
    logic [NL-1:0] mask, one;
    bit found;
    one  = 1;
    mask = (one << 3) | (one << 17);
    do_reset();
    i_rf_lock_timeout = 16'd8; i_rf_max_retry = 4'd3;
    i_signal_ok = '1; i_block_lock = ~mask; i_valid = 1'b1;
    cycle();
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (o_lane_restart !== '0) found = 1;
      n_tests++; if (o_lane_restart !== m_restart) begin n_fail++;
        $display("FAIL partial_pulse_timing cyc=%0d got=%h exp=%h", c, o_lane_restart, m_restart);
      end
    end
    n_tests++; if (!found || o_lane_restart !== mask) begin n_fail++;
      $display("FAIL partial_mask got=%h exp=%h", o_lane_restart, mask); end
    n_tests++; if (o_retry_count !== 4'd1) begin n_fail++;
      $display("FAIL partial_retry got=%0d exp=1", o_retry_count); end
    cycle();
    n_tests++; if (o_lane_restart !== '0) begin n_fail++;
      $display("FAIL partial_one_cycle got=%h exp=0", o_lane_restart); end
  endtask

  task automatic test_fail();
    int pulses;
    do_reset();
    i_rf_lock_timeout = 16'd4; i_rf_max_retry = 4'd2;
    i_signal_ok = '1; i_block_lock = ~20'h1; i_valid = 1'b1;
    cycle();
    pulses = 0;
    for (int c = 0; c < 200 && !o_lock_fail; c++) begin
      cycle();
      if (o_lane_restart !== '0) begin
        pulses++;
        n_tests++; if (o_lane_restart !== 20'h1) begin n_fail++;
          $display("FAIL fail_pulse_mask got=%h exp=%h", o_lane_restart, 20'h1); end
      end
    end
    n_tests++; if (o_lock_fail !== 1'b1) begin n_fail++;
      $display("FAIL fail_state got=%b exp=1", o_lock_fail); end
    n_tests++; if (pulses != 2) begin n_fail++;
      $display("FAIL fail_pulse_count got=%0d exp=2", pulses); end
    n_tests++; if (o_retry_count !== 4'd2) begin n_fail++;
      $display("FAIL fail_retry got=%0d exp=2", o_retry_count); end
    repeat (6) cycle();
    n_tests++; if (o_lock_fail !== 1'b1 || o_lane_restart !== '0) begin n_fail++;
      $display("FAIL fail_hold got=%b/%h exp=1/0", o_lock_fail, o_lane_restart); end
    i_signal_ok[5] = 1'b0;
    cycle();
    n_tests++; if (o_lock_fail !== 1'b0 || o_retry_count !== '0) begin n_fail++;
      $display("FAIL fail_to_idle got=%b/%0d exp=0/0", o_lock_fail, o_retry_count); end
    i_signal_ok = '1;
  endtask

  task automatic test_lock_loss();
    do_reset();
    i_rf_lock_timeout = 16'd100; i_rf_max_retry = 4'd3;
    i_signal_ok = '1; i_block_lock = '1; i_valid = 1'b1;
    cycle(); cycle();
    n_tests++; if (o_all_locked !== 1'b1) begin n_fail++;
      $display("FAIL loss_locked got=%b exp=1", o_all_locked); end
    i_block_lock[7] = 1'b0;
    cycle();
    i_block_lock[7] = 1'b1;
    n_tests++; if (o_all_locked !== 1'b0 || o_retry_count !== '0) begin n_fail++;
      $display("FAIL loss_to_wait got=%b/%0d exp=0/0", o_all_locked, o_retry_count); end
`ifdef BLOCK_SYNC_LOSS_CNT_EN
    n_tests++; if (o_lock_loss_count !== 16'd1) begin n_fail++;
      $display("FAIL loss_count got=%0d exp=1", o_lock_loss_count); end
`endif
    cycle();
    n_tests++; if (o_all_locked !== 1'b1) begin n_fail++;
      $display("FAIL loss_relock got=%b exp=1", o_all_locked); end
  endtask

  task automatic test_simultaneous();
    bit found;
    do_reset();
    i_rf_lock_timeout = 16'd3; i_rf_max_retry = 4'd3;
    i_signal_ok = '1; i_block_lock = ~20'h1; i_valid = 1'b1;
    cycle();
    for (int c = 0; c < 20; c++) begin
      if (m_phase == 1 && m_timer == 3) break;
      cycle();
    end
    i_block_lock = '1;
    cycle();
    n_tests++; if (o_all_locked !== 1'b1 || o_lane_restart !== '0) begin n_fail++;
      $display("FAIL simul_lock_wins got=%b/%h exp=1/0", o_all_locked, o_lane_restart); end
    do_reset();
    i_rf_lock_timeout = 16'd2; i_block_lock = ~20'h1;
    cycle();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (o_lane_restart !== '0) found = 1;
    end
    n_tests++; if (!found) begin n_fail++;
      $display("FAIL simul_pulse_seen got=0 exp=1"); end
    i_reset = 1'b1;
    cycle();
    i_reset = 1'b0;
    n_tests++; if (o_lane_restart !== '0 || o_retry_count !== '0) begin n_fail++;
      $display("FAIL simul_reset_pulse got=%h/%0d exp=0/0", o_lane_restart, o_retry_count); end
  endtask

  task automatic test_gating();
    int n;
    do_reset();
    i_rf_lock_timeout = 16'd10; i_rf_max_retry = 4'd3;
    i_signal_ok = '1; i_block_lock = ~20'h1; i_valid = 1'b1;
    cycle();
    repeat (3) cycle();
    i_valid = 1'b0;
    repeat (5) cycle();
    i_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(); n++;
      if (o_lane_restart !== '0) break;
    end
    n_tests++; if (n != 8) begin n_fail++;
      $display("FAIL gating_valid cycles=%0d exp=8", n); end
    do_reset();
    i_rf_lock_timeout = 16'd100; i_block_lock = '0;
    cycle();
    i_enable = 1'b0; i_block_lock = '1;
    repeat (4) cycle();
    n_tests++; if (o_all_locked !== 1'b0) begin n_fail++;
      $display("FAIL gating_enable_hold got=%b exp=0", o_all_locked); end
    i_enable = 1'b1;
    cycle();
    n_tests++; if (o_all_locked !== 1'b1) begin n_fail++;
      $display("FAIL gating_enable_resume got=%b exp=1", o_all_locked); end
  endtask

  task automatic test_random();
    logic [NL-1:0] one, drop;
    do_reset();
    i_rf_lock_timeout = 16'd3; i_rf_max_retry = 4'd2;
    for (int c = 0; c < 3000; c++) begin
      one = 1;
      i_reset  = ($urandom_range(0, 499) == 0);
      i_enable = ($urandom_range(0, 9) != 0);
      i_valid  = ($urandom_range(0, 3) != 0);
      i_signal_ok = ($urandom_range(0, 49) == 0) ? ~(one << $urandom_range(0, NL-1)) : '1;
      drop = (one << $urandom_range(0, NL-1)) | (one << $urandom_range(0, NL-1));
      i_block_lock = ($urandom_range(0, 4) == 0) ? '1 : ~drop;
      if ($urandom_range(0, 99) == 0) i_rf_lock_timeout = NBT'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) i_rf_max_retry = NBR'($urandom_range(0, 3));
      cycle();
      n_tests++; if (o_lane_restart !== m_restart) begin n_fail++;
        $display("FAIL rand_restart cyc=%0d got=%h exp=%h", c, o_lane_restart, m_restart); end
      n_tests++; if (o_all_locked !== (m_phase == 2)) begin n_fail++;
        $display("FAIL rand_all_locked cyc=%0d got=%b exp=%b", c, o_all_locked, m_phase == 2); end
      n_tests++; if (o_lock_fail !== (m_phase == 3)) begin n_fail++;
        $display("FAIL rand_lock_fail cyc=%0d got=%b exp=%b", c, o_lock_fail, m_phase == 3); end
      n_tests++; if (int'(o_retry_count) !== m_retry) begin n_fail++;
        $display("FAIL rand_retry cyc=%0d got=%0d exp=%0d", c, o_retry_count, m_retry); end
`ifdef BLOCK_SYNC_LOSS_CNT_EN
      n_tests++; if (int'(o_lock_loss_count) !== m_loss) begin n_fail++;
        $display("FAIL rand_loss cyc=%0d got=%0d exp=%0d", c, o_lock_loss_count, m_loss); end
`endif
    end
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_partial_timeout();
    test_fail();
    test_lock_loss();
    test_simultaneous();
    test_gating();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
